instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 77 +++++++
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bundle of the run/PC/flush/load inputs and the fetched
//                instruction outputs shared between the instruction-fetch
//                stage and whatever drives it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    should_run_processor  run enable; low = stopped / memory-load mode
//    pc [31:0]             program counter from the PC stage
//    flush                 taken branch; discard this cycle's fetch
//    load_en               instruction-memory write strobe (IDLE only)
//    load_addr [7:0]       instruction-memory write address
//    load_data [INSTR_W]   instruction-memory write data
//    instr [INSTR_W]       registered instruction to decode
//    instr_valid           instr carries a real instruction this cycle
//    pc_out [31:0]         PC that instr was fetched from
//    done                  program has halted
//    fetch_count [15:0]    valid-fetch counter (only with IF_PERF_CNT_EN)
//  Modports
//    master : drives the inputs of the fetch stage, observes its outputs
//    slave  : the fetch stage itself
//  Build option
//    IF_PERF_CNT_EN        adds the fetch_count signal
// ============================================================================
interface instr_fetch_if #(
    parameter int INSTR_W = 9
);
    logic               should_run_processor;
    logic [31:0]        pc;
    logic               flush;
    logic               load_en;
    logic [7:0]         load_addr;
    logic [INSTR_W-1:0] load_data;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [31:0]        pc_out;
    logic               done;
`ifdef IF_PERF_CNT_EN
    logic [15:0]        fetch_count;
`endif

    modport master (
`ifdef IF_PERF_CNT_EN
        input  fetch_count,
`endif
        output should_run_processor,
        output pc,
        output flush,
        output load_en,
        output load_addr,
        output load_data,
        input  instr,
        input  instr_valid,
        input  pc_out,
        input  done
    );

    modport slave (
`ifdef IF_PERF_CNT_EN
        output fetch_count,
`endif
        input  should_run_processor,
        input  pc,
        input  flush,
        input  load_en,
        input  load_addr,
        input  load_data,
        output instr,
        output instr_valid,
        output pc_out,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction-fetch stage with a private instruction memory.
//                The memory is loaded while the core is stopped (IDLE); when
//                run is raised the stage fetches mem[pc] every cycle with a
//                one-cycle registered read, inserts a NOP bubble on flush and
//                stops in HALTED after presenting the halt opcode.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    input   rising-edge clock
//    reset  input   asynchronous, active-high reset (memory is not cleared)
//    bus    slave   instr_fetch_if: run / pc / flush / load inputs,
//                   instr / instr_valid / pc_out / done outputs
//  Parameters
//    INSTR_W      instruction width in bits
//    IMEM_DEPTH   instruction memory words (2..256), addressed by pc[7:0]
//    HALT_OPCODE  instruction value that ends the program
//  Build option
//    IF_PERF_CNT_EN  adds a saturating 16-bit count of valid fetches on
//                    bus.fetch_count, cleared when a run starts
// ============================================================================
module instr_fetch #(
    parameter int                 INSTR_W     = 9,
    parameter int                 IMEM_DEPTH  = 256,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = 9'h1FF
) (
    input  wire logic    clk,
    input  wire logic    reset,
    instr_fetch_if.slave bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];

    state_t             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_valid_q;
    logic [31:0]        pc_out_q;
    logic               done_q;
`ifdef IF_PERF_CNT_EN
    logic [15:0]        fetch_count_q;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               pc_in_range_d;
    logic [INSTR_W-1:0] fetch_word_d;
    logic               mem_wr_en_d;

    always_comb begin
        // Anything outside the populated memory reads as the halt opcode,
        // so a runaway PC stops the core instead of executing garbage.
        pc_in_range_d = (bus.pc[31:8] == 24'd0) &&
                        ({24'd0, bus.pc[7:0]} < 32'(IMEM_DEPTH));
        fetch_word_d  = HALT_OPCODE;
        if (pc_in_range_d) begin
            fetch_word_d = mem_q[bus.pc[AW-1:0]];
        end

        // Loading is only legal while stopped. The IDLE->FETCH edge still
        // counts as IDLE, so a write issued together with run still lands.
        mem_wr_en_d = bus.load_en && (state_q == ST_IDLE) &&
                      ({24'd0, bus.load_addr} < 32'(IMEM_DEPTH));
    end

    // ------------------------------------------------------------------
    // Instruction memory write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_wr_en_d) begin
            mem_q[bus.load_addr[AW-1:0]] <= bus.load_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= 32'd0;
            done_q        <= 1'b0;
`ifdef IF_PERF_CNT_EN
            fetch_count_q <= 16'd0;
`endif
        end else if (!bus.should_run_processor) begin
            // Dropping run aborts everything, whatever the state.
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= 32'd0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The starting edge only arms the stage; the first
                    // fetch happens on the following edge.
                    state_q       <= ST_FETCH;
                    instr_q       <= '0;
                    instr_valid_q <= 1'b0;
                    pc_out_q      <= 32'd0;
                    done_q        <= 1'b0;
`ifdef IF_PERF_CNT_EN
                    fetch_count_q <= 16'd0;
`endif
                end

                ST_FETCH: begin
                    pc_out_q <= bus.pc;
                    if (bus.flush) begin
                        // Bubble: flush also overrides a halt opcode here,
                        // because the word belongs to the wrong path.
                        instr_q       <= '0;
                        instr_valid_q <= 1'b0;
                    end else begin
                        instr_q       <= fetch_word_d;
                        instr_valid_q <= 1'b1;
`ifdef IF_PERF_CNT_EN
                        if (fetch_count_q != 16'hFFFF) begin
                            fetch_count_q <= fetch_count_q + 16'd1;
                        end
`endif
                        // The halt word is still presented as valid; the
                        // done flag follows one cycle later from HALTED.
                        if (fetch_word_d == HALT_OPCODE) begin
                            state_q <= ST_HALTED;
                        end
                    end
                end

                ST_HALTED: begin
                    // instr and pc_out keep the halt word and its address.
                    instr_valid_q <= 1'b0;
                    done_q        <= 1'b1;
                end

                default: begin
                    state_q       <= ST_IDLE;
                    instr_q       <= '0;
                    instr_valid_q <= 1'b0;
                    pc_out_q      <= 32'd0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.done        = done_q;
`ifdef IF_PERF_CNT_EN
    assign bus.fetch_count = fetch_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Scoreboard bench for instr_fetch. The driver applies one
//                directed vector per clock and queues the hand-computed
//                outputs expected after that edge; an independent monitor
//                pops and compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_if #(.INSTR_W(9)) bus ();

    instr_fetch #(
        .INSTR_W    (9),
        .IMEM_DEPTH (256),
        .HALT_OPCODE(9'h1FF)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        int           cyc;
        logic [8:0]   instr;
        logic         valid;
        logic [31:0]  pc_out;
        logic         done;
        logic         use_cnt;
        logic [15:0]  cnt;
        logic [127:0] name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_next(input logic [8:0] ei, input logic ev,
                               input logic [31:0] ep, input logic ed,
                               input logic [127:0] nm,
                               input logic uc = 1'b0,
                               input logic [15:0] ec = 16'd0);
        exp_t e;
        e.cyc     = cyc + 1;
        e.instr   = ei;
        e.valid   = ev;
        e.pc_out  = ep;
        e.done    = ed;
        e.use_cnt = uc;
        e.cnt     = ec;
        e.name    = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic run, input logic [31:0] p, input logic fl,
                        input logic [8:0] ei, input logic ev,
                        input logic [31:0] ep, input logic ed,
                        input logic [127:0] nm,
                        input logic uc = 1'b0,
                        input logic [15:0] ec = 16'd0);
        bus.should_run_processor = run;
        bus.pc                   = p;
        bus.flush                = fl;
        expect_next(ei, ev, ep, ed, nm, uc, ec);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Monitor / comparator
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %0s: expectation for cycle %0d never checked (now %0d)",
                         e.name, e.cyc, cyc);
            end
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                bad = (bus.instr !== e.instr) || (bus.instr_valid !== e.valid) ||
                      (bus.pc_out !== e.pc_out) || (bus.done !== e.done);
`ifdef IF_PERF_CNT_EN
                if (e.use_cnt && (bus.fetch_count !== e.cnt)) bad = 1'b1;
`endif
                if (bad) begin
                    n_err++;
                    $display("FAIL %0s: got instr=%h valid=%b pc_out=%h done=%b, want instr=%h valid=%b pc_out=%h done=%b",
                             e.name, bus.instr, bus.instr_valid, bus.pc_out, bus.done,
                             e.instr, e.valid, e.pc_out, e.done);
`ifdef IF_PERF_CNT_EN
                    if (e.use_cnt)
                        $display("FAIL %0s: fetch_count got %h want %h",
                                 e.name, bus.fetch_count, e.cnt);
`endif
                end
            end
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
                 n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [8:0] image [8];

    initial begin
        image = '{9'h011, 9'h022, 9'h1FF, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077};

        bus.should_run_processor = 1'b0;
        bus.pc        = 32'd0;
        bus.flush     = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = 8'd0;
        bus.load_data = 9'd0;
        tick();

        // Reset held
        step(1'b0, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "reset");
        reset = 1'b0;

        // Load image while stopped
        for (int i = 0; i < 8; i++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = 8'(i);
            bus.load_data = image[i];
            step(1'b0, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "idle_load");
        end
        bus.load_en = 1'b0;

        // Straight-line program ending in halt
        step(1'b1, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "start");
        step(1'b1, 32'd0, 1'b0, 9'h011, 1'b1, 32'd0, 1'b0, "fetch0");
        step(1'b1, 32'd1, 1'b0, 9'h022, 1'b1, 32'd1, 1'b0, "fetch1");
        step(1'b1, 32'd2, 1'b0, 9'h1FF, 1'b1, 32'd2, 1'b0, "fetch_halt");
        step(1'b1, 32'd3, 1'b0, 9'h1FF, 1'b0, 32'd2, 1'b1, "halted");
        step(1'b1, 32'd4, 1'b1, 9'h1FF, 1'b0, 32'd2, 1'b1, "halt_hold");
        step(1'b0, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "halt_stop");

        // Flush bubble, and flush beating a halt word
        step(1'b1, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "start2");
        step(1'b1, 32'd4, 1'b0, 9'h044, 1'b1, 32'd4, 1'b0, "fetch4");
        step(1'b1, 32'd5, 1'b1, 9'h000, 1'b0, 32'd5, 1'b0, "flush");
        step(1'b1, 32'd5, 1'b0, 9'h055, 1'b1, 32'd5, 1'b0, "after_flush");
        step(1'b1, 32'd2, 1'b1, 9'h000, 1'b0, 32'd2, 1'b0, "flush_halt");
        step(1'b1, 32'd6, 1'b0, 9'h066, 1'b1, 32'd6, 1'b0, "still_fetch");

        // Write attempt while fetching must be ignored
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd3;
        bus.load_data = 9'h0AA;
        step(1'b1, 32'd7, 1'b0, 9'h077, 1'b1, 32'd7, 1'b0, "fetch_ld");
        bus.load_en   = 1'b0;
        step(1'b1, 32'd3, 1'b0, 9'h033, 1'b1, 32'd3, 1'b0, "mem3_kept");

        // Out-of-range PC reads as halt
        step(1'b1, 32'h100, 1'b0, 9'h1FF, 1'b1, 32'h100, 1'b0, "oor");
        step(1'b1, 32'd0,   1'b0, 9'h1FF, 1'b0, 32'h100, 1'b1, "oor_done");
        step(1'b0, 32'd0,   1'b0, 9'h000, 1'b0, 32'd0,   1'b0, "stop2");

        // Write issued on the same edge as the run start still lands
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd8;
        bus.load_data = 9'h0BC;
        step(1'b1, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "start_ld");
        bus.load_en   = 1'b0;
        step(1'b1, 32'd8, 1'b0, 9'h0BC, 1'b1, 32'd8, 1'b0, "ld_on_go");

        // Short reset pulse between edges while fetching: only an
        // asynchronous reset can clear the stage here.
        step(1'b1, 32'd1, 1'b0, 9'h022, 1'b1, 32'd1, 1'b0, "fetch1b");
        bus.pc = 32'd4;
        expect_next(9'h000, 1'b0, 32'd0, 1'b0, "rst_pulse");
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        step(1'b1, 32'd4, 1'b0, 9'h044, 1'b1, 32'd4, 1'b0, "post_rst");
        step(1'b1, 32'd2, 1'b0, 9'h1FF, 1'b1, 32'd2, 1'b0, "halt_b");
        step(1'b1, 32'd0, 1'b0, 9'h1FF, 1'b0, 32'd2, 1'b1, "done_b");
        step(1'b0, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "stop3");

        // High PC bit set is also out of range
        step(1'b1, 32'd0,         1'b0, 9'h000, 1'b0, 32'd0,         1'b0, "start4");
        step(1'b1, 32'h8000_0001, 1'b0, 9'h1FF, 1'b1, 32'h8000_0001, 1'b0, "oor_hi");
        step(1'b0, 32'd0,         1'b0, 9'h000, 1'b0, 32'd0,         1'b0, "stop4");

`ifdef IF_PERF_CNT_EN
        step(1'b1, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "cnt_clr", 1'b1, 16'd0);
        step(1'b1, 32'd3, 1'b0, 9'h033, 1'b1, 32'd3, 1'b0, "cnt1");
        step(1'b1, 32'd4, 1'b0, 9'h044, 1'b1, 32'd4, 1'b0, "cnt2");
        step(1'b1, 32'd5, 1'b1, 9'h000, 1'b0, 32'd5, 1'b0, "cnt_bub");
        step(1'b1, 32'd5, 1'b0, 9'h055, 1'b1, 32'd5, 1'b0, "cnt3");
        step(1'b1, 32'd6, 1'b0, 9'h066, 1'b1, 32'd6, 1'b0, "cnt4", 1'b1, 16'd4);
        bus.pc = 32'd3;
        for (int i = 0; i < 70000; i++) tick();
        step(1'b1, 32'd3, 1'b0, 9'h033, 1'b1, 32'd3, 1'b0, "cnt_sat", 1'b1, 16'hFFFF);
        step(1'b0, 32'd0, 1'b0, 9'h000, 1'b0, 32'd0, 1'b0, "stop5");
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
